// File: rtl/mem_access_pkg.sv
// Shared types for the load/store front end.
// Size encodings, FSM states, lane count, request legality check.
package mem_access_pkg;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int BYTE_W = DATA_W / LANES;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } sizeT;

  typedef enum logic [1:0] {
    IDLE,
    RMW,
    RESP
  } stateT;

  // Illegal size, odd half, or word not on lane 0.
  function automatic logic isBadRequest(
    input sizeT       size,
    input logic [1:0] lane
  );
    case (size)
      SIZE_HALF: return lane[0];
      SIZE_WORD: return lane != 2'b00;
      SIZE_BAD:  return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper: extract+extend for loads, merge for sub-word stores.
// Ports: word/lane/size/isUnsigned -> extData; oldWord/newData -> mergedWord.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        lane,
  input  sizeT              size,
  input  logic              isUnsigned,
  output logic [DATA_W-1:0] extData,
  input  logic [DATA_W-1:0] oldWord,
  input  logic [DATA_W-1:0] newData,
  output logic [DATA_W-1:0] mergedWord
);

  logic [BYTE_W-1:0]   byteSel;
  logic [2*BYTE_W-1:0] halfSel;
  logic                signBit;

  always_comb begin
    byteSel = word[BYTE_W*lane +: BYTE_W];
    halfSel = lane[1] ? word[31:16] : word[15:0];
    signBit = 1'b0;
    extData = '0;
    case (size)
      SIZE_BYTE: begin
        signBit = ~isUnsigned & byteSel[BYTE_W-1];
        extData = {{24{signBit}}, byteSel};
      end
      SIZE_HALF: begin
        signBit = ~isUnsigned & halfSel[2*BYTE_W-1];
        extData = {{16{signBit}}, halfSel};
      end
      SIZE_WORD: extData = word;
      default:   extData = '0;
    endcase
  end

  always_comb begin
    mergedWord = oldWord;
    case (size)
      SIZE_BYTE: mergedWord[BYTE_W*lane +: BYTE_W] = newData[7:0];
      SIZE_HALF: begin
        if (lane[1]) mergedWord[31:16] = newData[15:0];
        else         mergedWord[15:0]  = newData[15:0];
      end
      SIZE_WORD: mergedWord = newData;
      default:   mergedWord = oldWord;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-only RAM; sub-word stores via RMW.
// Ports: req_* in, rsp_* out, mem_* RAM ports, report prints status.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  report
);

  stateT                 state;
  logic [DATA_WIDTH-1:0] mergeReg;
  logic [ADDR_WIDTH-1:0] rmwAddr;
  logic [31:0]           loadCount;
  logic [31:0]           storeCount;
  logic [31:0]           errorCount;

  logic [ADDR_WIDTH-1:0] wordAddr;
  logic [1:0]            lane;
  sizeT                  size;
  logic                  accept;
  logic                  reqErr;
  logic                  isLoad;
  logic                  isWordStore;
  logic                  isSubStore;
  logic [DATA_WIDTH-1:0] loadData;
  logic [DATA_WIDTH-1:0] mergedWord;

  assign wordAddr  = req_addr[ADDR_WIDTH+1:2];
  assign lane      = req_addr[1:0];
  assign size      = sizeT'(req_size);
  assign req_ready = (state == IDLE);

  // Gating with reset keeps the RAM untouched while reset is held.
  assign accept      = req_valid & req_ready & reset;
  assign reqErr      = isBadRequest(size, lane);
  assign isLoad      = ~reqErr & ~req_write;
  assign isWordStore = ~reqErr & req_write & (size == SIZE_WORD);
  assign isSubStore  = ~reqErr & req_write & (size != SIZE_WORD);

  mem_lane_align align (
    .word       (mem_read_data),
    .lane       (lane),
    .size       (size),
    .isUnsigned (req_unsigned),
    .extData    (loadData),
    .oldWord    (mem_read_data),
    .newData    (req_wdata),
    .mergedWord (mergedWord)
  );

  // Read and write are never enabled together.
  always_comb begin
    mem_read_enable   = 1'b0;
    mem_read_address  = '0;
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    if (state == RMW) begin
      mem_write_enable  = 1'b1;
      mem_write_address = rmwAddr;
      mem_write_data    = mergeReg;
    end else if (accept) begin
      if (isLoad || isSubStore) begin
        mem_read_enable  = 1'b1;
        mem_read_address = wordAddr;
      end else if (isWordStore) begin
        mem_write_enable  = 1'b1;
        mem_write_address = wordAddr;
        mem_write_data    = req_wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
      mergeReg   <= '0;
      rmwAddr    <= '0;
      loadCount  <= '0;
      storeCount <= '0;
      errorCount <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              reqErr: begin
                rsp_error  <= 1'b1;
                rsp_data   <= '0;
                rsp_valid  <= 1'b1;
                errorCount <= errorCount + 32'd1;
                state      <= RESP;
              end
              isLoad: begin
                rsp_error <= 1'b0;
                rsp_data  <= loadData;
                rsp_valid <= 1'b1;
                loadCount <= loadCount + 32'd1;
                state     <= RESP;
              end
              isWordStore: begin
                rsp_error  <= 1'b0;
                rsp_data   <= '0;
                rsp_valid  <= 1'b1;
                storeCount <= storeCount + 32'd1;
                state      <= RESP;
              end
              isSubStore: begin
                rsp_error  <= 1'b0;
                rsp_data   <= '0;
                mergeReg   <= mergedWord;
                rmwAddr    <= wordAddr;
                storeCount <= storeCount + 32'd1;
                state      <= RMW;
              end
            endcase
          end
        end
        RMW: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report) begin
      $display("mem_access_unit core=%0d state=%s loads=%0d stores=%0d errors=%0d rd=%b/%h wr=%b/%h/%h",
               CORE, state.name(), loadCount, storeCount, errorCount,
               mem_read_enable, mem_read_address,
               mem_write_enable, mem_write_address, mem_write_data);
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit.
// Table vectors, reset corner sequences, random traffic vs byte-array model.
module tb_mem_access_unit;

  localparam int AW = 8;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] expData;
    logic        expErr;
    int          expLat;
    int          expRd;
    int          expWr;
  } vecT;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic          reqWrite = 1'b0;
  logic [1:0]    reqSize = 2'b00;
  logic          reqUns = 1'b0;
  logic [AW+1:0] reqAddr = '0;
  logic [31:0]   reqWdata = '0;
  logic          rspValid;
  logic          rspReady = 1'b1;
  logic [31:0]   rspData;
  logic          rspError;
  logic          memReadEn;
  logic [AW-1:0] memReadAddr;
  logic [31:0]   memReadData;
  logic          memWriteEn;
  logic [AW-1:0] memWriteAddr;
  logic [31:0]   memWriteData;
  logic          report = 1'b0;

  logic [31:0] ram [0:255];
  logic [7:0]  refMem [0:1023];

  int total = 0;
  int bad = 0;
  int bothBad = 0;
  int idleBad = 0;

  always #5 clock = ~clock;

  mem_access_unit #(.CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clock             (clock),
    .reset             (resetN),
    .req_valid         (reqValid),
    .req_ready         (reqReady),
    .req_write         (reqWrite),
    .req_size          (reqSize),
    .req_unsigned      (reqUns),
    .req_addr          (reqAddr),
    .req_wdata         (reqWdata),
    .rsp_valid         (rspValid),
    .rsp_ready         (rspReady),
    .rsp_data          (rspData),
    .rsp_error         (rspError),
    .mem_read_enable   (memReadEn),
    .mem_read_address  (memReadAddr),
    .mem_read_data     (memReadData),
    .mem_write_enable  (memWriteEn),
    .mem_write_address (memWriteAddr),
    .mem_write_data    (memWriteData),
    .report            (report)
  );

  assign memReadData = ram[memReadAddr];

  always @(posedge clock) begin
    if (memWriteEn) ram[memWriteAddr] <= memWriteData;
  end

  always @(negedge clock) begin
    if (resetN) begin
      if (memReadEn && memWriteEn) bothBad++;
      if (!memReadEn && memReadAddr != '0) idleBad++;
      if (!memWriteEn && (memWriteAddr != '0 || memWriteData != '0)) idleBad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] refWord(input int w);
    return {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};
  endfunction

  // Byte-level model: little-endian bytes, spec legality rule.
  task automatic refAccess(input vecT v, output vecT r);
    int n;
    logic [31:0] val;
    logic err;
    r = v;
    err = (v.size == 2'd3) || (v.size == 2'd1 && v.addr[0]) ||
          (v.size == 2'd2 && v.addr[1:0] != 2'b00);
    n = 1 << v.size;
    val = '0;
    r.expErr = err;
    r.expData = '0;
    r.expLat = (!err && v.write && v.size != 2'd2) ? 2 : 1;
    r.expRd = (!err && (!v.write || v.size != 2'd2)) ? 1 : 0;
    r.expWr = (!err && v.write) ? 1 : 0;
    if (!err) begin
      if (v.write) begin
        for (int i = 0; i < n; i++) refMem[int'(v.addr) + i] = v.wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) val[8*i +: 8] = refMem[int'(v.addr) + i];
        if (!v.uns && n == 1 && val[7]) val[31:8] = '1;
        if (!v.uns && n == 2 && val[15]) val[31:16] = '1;
        r.expData = val;
      end
    end
  endtask

  // Called and returns at posedge+1 with the unit idle.
  task automatic doReq(input vecT v, input string tag);
    int guard;
    int lat;
    int nRd;
    int nWr;
    logic [31:0] d;
    guard = 0;
    reqValid = 1'b1;
    reqWrite = v.write;
    reqSize = v.size;
    reqUns = v.uns;
    reqAddr = v.addr;
    reqWdata = v.wdata;
    rspReady = (v.hold == 0);
    #1;
    while (!reqReady && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    nRd = int'(memReadEn);
    nWr = int'(memWriteEn);
    @(posedge clock); #1;
    reqValid = 1'b0;
    lat = 1;
    forever begin
      #1;
      nRd += int'(memReadEn);
      nWr += int'(memWriteEn);
      if (rspValid || lat >= 8) break;
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, v.expLat);
    chk({tag, "_data"}, rspData, v.expData);
    chk({tag, "_err"}, rspError, v.expErr);
    chk({tag, "_rd"}, nRd, v.expRd);
    chk({tag, "_wr"}, nWr, v.expWr);
    d = rspData;
    for (int k = 0; k < v.hold; k++) begin
      chk({tag, "_holdvalid"}, rspValid, 1);
      chk({tag, "_holdready"}, reqReady, 0);
      chk({tag, "_holddata"}, rspData, d);
      @(posedge clock); #2;
    end
    rspReady = 1'b1;
    @(posedge clock); #1;
    chk({tag, "_idle"}, {rspValid, reqReady}, 2'b01);
  endtask

  function automatic vecT mk(input logic w, input logic [1:0] s, input logic u,
                             input logic [9:0] a, input logic [31:0] wd, input int h,
                             input logic [31:0] ed, input logic ee, input int el,
                             input int er, input int ew);
    vecT v;
    v.write = w; v.size = s; v.uns = u; v.addr = a; v.wdata = wd; v.hold = h;
    v.expData = ed; v.expErr = ee; v.expLat = el; v.expRd = er; v.expWr = ew;
    return v;
  endfunction

  initial begin
    vecT tbl [16];
    vecT v;
    vecT r;
    logic [31:0] w4;
    int memBad;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] x;
      x = (i == 4) ? 32'h8899AABB : $urandom;
      ram[i] <= x;
      for (int b = 0; b < 4; b++) refMem[4*i+b] = x[8*b +: 8];
    end

    tbl[0]  = mk(0, 2'd0, 0, 10'h011, 0, 0, 32'hFFFFFFAA, 0, 1, 1, 0);
    tbl[1]  = mk(0, 2'd0, 1, 10'h011, 0, 0, 32'h000000AA, 0, 1, 1, 0);
    tbl[2]  = mk(0, 2'd1, 0, 10'h012, 0, 0, 32'hFFFF8899, 0, 1, 1, 0);
    tbl[3]  = mk(0, 2'd1, 1, 10'h010, 0, 0, 32'h0000AABB, 0, 1, 1, 0);
    tbl[4]  = mk(1, 2'd0, 0, 10'h012, 32'h0000005C, 0, 0, 0, 2, 1, 1);
    tbl[5]  = mk(0, 2'd2, 0, 10'h010, 0, 0, 32'h885CAABB, 0, 1, 1, 0);
    tbl[6]  = mk(1, 2'd1, 0, 10'h013, 32'h00001234, 0, 0, 1, 1, 0, 0);
    tbl[7]  = mk(1, 2'd2, 0, 10'h010, 32'hDEADBEEF, 3, 0, 0, 1, 0, 1);
    tbl[8]  = mk(0, 2'd2, 0, 10'h010, 0, 0, 32'hDEADBEEF, 0, 1, 1, 0);
    tbl[9]  = mk(1, 2'd1, 0, 10'h010, 32'h1111CAFE, 0, 0, 0, 2, 1, 1);
    tbl[10] = mk(0, 2'd0, 0, 10'h013, 0, 0, 32'hFFFFFFDE, 0, 1, 1, 0);
    tbl[11] = mk(0, 2'd2, 0, 10'h011, 0, 0, 0, 1, 1, 0, 0);
    tbl[12] = mk(0, 2'd3, 0, 10'h010, 0, 0, 0, 1, 1, 0, 0);
    tbl[13] = mk(0, 2'd1, 1, 10'h010, 0, 0, 32'h0000CAFE, 0, 1, 1, 0);
    tbl[14] = mk(1, 2'd0, 0, 10'h010, 32'hFFFFFF80, 1, 0, 0, 2, 1, 1);
    tbl[15] = mk(0, 2'd0, 0, 10'h010, 0, 0, 32'hFFFFFF80, 0, 1, 1, 0);

    // Reset held with a request pending: nothing is accepted.
    reqValid = 1'b1;
    reqSize = 2'd2;
    reqAddr = 10'h010;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", reqReady, 1);
    chk("rst_rspvalid", rspValid, 0);
    chk("rst_rspdata", rspData, 0);
    chk("rst_rsperr", rspError, 0);
    chk("rst_rden", memReadEn, 0);
    reqValid = 1'b0;
    resetN = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 16; i++) begin
      refAccess(tbl[i], r);
      doReq(tbl[i], $sformatf("vec%0d", i));
    end
    chk("ram_word4", ram[4], 32'hDEADCA80);

    // Reset during the RMW write cycle drops the write.
    w4 = refWord(4);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqUns = 1'b0;
    reqAddr = 10'h010; reqWdata = 32'h00000077; rspReady = 1'b1;
    @(posedge clock); #1;
    reqValid = 1'b0;
    chk("rmw_wren", memWriteEn, 1);
    resetN = 1'b0;
    #1;
    chk("rmwrst_wren", memWriteEn, 0);
    chk("rmwrst_valid", rspValid, 0);
    @(posedge clock); #1;
    resetN = 1'b1;
    @(posedge clock); #1;
    chk("rmwrst_word4", ram[4], w4);
    chk("rmwrst_ready", reqReady, 1);
    chk("rmwrst_valid2", rspValid, 0);

    // Reset while a response waits: it is lost.
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'd2; reqAddr = 10'h010;
    rspReady = 1'b0;
    @(posedge clock); #1;
    reqValid = 1'b0;
    chk("resprst_pre", rspValid, 1);
    resetN = 1'b0;
    #1;
    chk("resprst_valid", rspValid, 0);
    chk("resprst_data", rspData, 0);
    @(posedge clock); #1;
    resetN = 1'b1;
    rspReady = 1'b1;
    @(posedge clock); #1;
    chk("resprst_idle", {rspValid, reqReady}, 2'b01);

    for (int i = 0; i < 300; i++) begin
      v.write = 1'($urandom_range(0, 1));
      v.size = 2'($urandom_range(0, 3));
      v.uns = 1'($urandom_range(0, 1));
      v.addr = 10'($urandom_range(0, 63));
      v.wdata = $urandom;
      v.hold = $urandom_range(0, 2);
      refAccess(v, r);
      doReq(r, $sformatf("rnd%0d", i));
    end

    memBad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== refWord(i)) memBad++;
    chk("ram_contents", memBad, 0);
    chk("both_enables", bothBad, 0);
    chk("idle_ports", idleBad, 0);

    report = 1'b1;
    @(posedge clock); #1;
    report = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Load/store front end that sits directly upstream of the core's single-port-per-direction block data RAM.
- Accepts byte, halfword and word requests from the core's memory stage using a valid/ready handshake, and drives the RAM's word-addressed read/write ports.
- The RAM has no byte enables, so sub-word stores are done as a two-cycle read-modify-write.
- Returns sign- or zero-extended load data on a valid/ready response channel and flags misaligned or illegal requests.

## Interface
- CORE, 0, core index printed in report output
- DATA_WIDTH, 32, word width; fixed at 32 (four byte lanes)
- ADDR_WIDTH, 8, RAM word-address width; request byte address is ADDR_WIDTH+2 bits
- clock  input  1  single clock; all state on posedge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_write  input  1  1=store, 0=load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  zero-extend loads when 1
- req_addr  input  ADDR_WIDTH+2  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes response
- rsp_data  output  32  extended load data; 0 for stores and errors
- rsp_error  output  1  misaligned or illegal size
- mem_read_enable  output  1  RAM read enable
- mem_read_address  output  ADDR_WIDTH  RAM read word address
- mem_read_data  input  32  RAM same-cycle read data
- mem_write_enable  output  1  RAM write enable
- mem_write_address  output  ADDR_WIDTH  RAM write word address
- mem_write_data  output  32  RAM write data
- report  input  1  print state and counters this cycle

## Operation
- **Word address and lane:** word address = req_addr[ADDR_WIDTH+1:2]; lane = req_addr[1:0].
- **Error check:** a request is an error when req_size = 11, when it is a half with lane[0] = 1, or when it is a word with lane != 0.
- **FSM states:** IDLE, RMW, RESP. req_ready = (state == IDLE).
- **IDLE, on accept (req_valid & req_ready):**
  - Error: no RAM access. Latch rsp_error = 1 and rsp_data = 0, then go to RESP.
  - Load: same cycle, mem_read_enable = 1 at the word address. Extract the byte (mem_read_data[8*lane+:8]) or the half (lane[1] selects the upper half), extend it per req_unsigned into rsp_data, then go to RESP.
  - Word store: same cycle, mem_write_enable = 1 with mem_write_data = req_wdata. Go to RESP.
  - Byte/half store: same cycle, mem_read_enable = 1. Latch the word address, then merge req_wdata[7:0] or [15:0] into the lane(s) of mem_read_data and hold the result in a merge register. Go to RMW.
- **RMW:** mem_write_enable = 1 with the latched address and merged word, then go to RESP.
- **RESP:** rsp_valid = 1 and rsp_data/rsp_error are held stable. Go to IDLE when rsp_ready = 1; otherwise stay.
- **RAM port discipline:**
  - The unit never asserts read and write enable in the same cycle, so the RAM's write-to-read forwarding path is never exercised.
  - Outside the cases above, both enables are 0 and addresses/data are 0.
- **Counters:** three 32-bit wrapping counters, load_count, store_count and error_count, each incremented on accept.
- **report:** when report is high, $display the CORE index, state, the three counters and the current RAM port values.

## Timing
- **Reset values (reset low):** state = IDLE, rsp_valid = 0, rsp_data = 0, rsp_error = 0, all counters 0, merge register 0. req_ready is 1 while reset is low; requests are not accepted during reset.
- **Reset mid-RMW:** the pending write is dropped and the RAM is unmodified.
- **Reset in RESP:** the response is lost.
- **Latency from accept in cycle N:**
  - Load, word store and error: rsp_valid in cycle N+1.
  - Sub-word store: RAM write in N+1, rsp_valid in N+2.
- **Throughput:** at most one request per two cycles (per three for sub-word stores). No request is accepted while in RESP, even when rsp_ready = 1.
- **Stability:** req_* are sampled only in the accept cycle. Load data uses same-cycle RAM output, so mem_read_data must be valid in the accept cycle.

## Structure
- **Package mem_access_pkg:**
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_BAD;
  - state enum IDLE/RMW/RESP;
  - LANES = 4.
- **Sub-module mem_lane_align (combinational):**
  - extract: word, lane, size, unsigned → extended data;
  - merge: old word, new data, lane, size → merged word.
  - Instantiated once, with both functions used.

## Test plan
All scenarios use RAM word 4 preloaded with 0x8899AABB.

1. Signed byte load at req_addr 0x11 → rsp_data 0xFFFFFFAA in cycle N+1. Repeated with req_unsigned = 1 → 0x000000AA. No RAM write occurs.
2. Byte store of 0x5C at 0x12 → read word 4 in N, write 0x885CAABB in N+1, rsp_valid in N+2. A following word load of 0x10 returns 0x885CAABB.
3. Half store at 0x13 → rsp_error = 1 and rsp_data = 0 in N+1, no RAM enables asserted, error_count = 1.
4. Word store of 0xDEADBEEF at 0x10 with rsp_ready held low for 3 cycles → rsp_valid stays high and req_ready stays low until rsp_ready rises, then return to IDLE.
5. Half load at 0x12 → 0xFFFF8899. Assert reset in the RMW cycle of a byte store to 0x10 → word 4 is unchanged, rsp_valid = 0, and req_ready = 1 after release.
